// File: rtl/uart_byte_receiver_if.sv
// uart_byte_receiver_if
//   Byte stream carrying received UART bytes from the receiver to the consumer.
//   data_out        received byte (head of the receive buffer)
//   data_out_valid  data_out holds an unconsumed byte
//   data_out_ready  consumer takes data_out when valid && ready at a rising clock edge
//   modport master: byte producer (receiver); modport slave: byte consumer.
interface uart_byte_receiver_if;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;

   modport master (output data_out, output data_out_valid, input data_out_ready);
   modport slave  (input data_out, input data_out_valid, output data_out_ready);
endinterface

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver
//   Oversampling 8N1 UART receiver (LSB first). Recovered bytes are buffered and
//   offered on a valid/ready byte stream. Framing errors and overruns are reported
//   as single-cycle pulses.
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-low
//   uart_receive   raw serial line, idle high, asynchronous to clock
//   byte_stream    uart_byte_receiver_if.master: data_out / data_out_valid / data_out_ready
//   framing_error  1-cycle pulse, stop bit sampled low
//   overrun        1-cycle pulse, completed byte dropped because the buffer was full
//   busy           high whenever the receive FSM is not in IDLE
// Configuration
//   UART_RX_FIFO_EN  defined: FIFO_DEPTH-entry first-word-fall-through FIFO.
//                    undefined: single holding register, FIFO_DEPTH unused.
module uart_byte_receiver #(
   parameter int CLOCK_FREQUENCY = 100,
   parameter int BAUD_RATE       = 10,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        uart_receive,
   uart_byte_receiver_if.master        byte_stream,
   output logic                        framing_error,
   output logic                        overrun,
   output logic                        busy
);

   localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
   localparam int HALF           = CYCLES_PER_BIT / 2;
   localparam int CW             = $clog2(CYCLES_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CYCLES_PER_BIT - 1);

   generate
      if (CYCLES_PER_BIT < 4) begin : g_bad_rate
         $error("uart_byte_receiver: CLOCK_FREQUENCY/BAUD_RATE must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [1:0]    rx_pipe;   // [0] metastable stage, [1] synchronized line
   logic          rx;
   logic          push_now;
   logic          pop;
   logic          full;

   assign rx = rx_pipe[1];

   // Reset to idle-high so a reset never fakes a start edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rx_pipe <= 2'b11;
      else        rx_pipe <= {rx_pipe[0], uart_receive};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= WAIT_IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         framing_error <= 1'b0;
         busy          <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         case (state)
            // A line held low (break, or reset released mid-frame) must go high
            // before a new start bit is trusted.
            WAIT_IDLE: begin
               if (rx) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  busy  <= 1'b1;
               end
            end
            IDLE: begin
               busy <= 1'b0;
               if (!rx) begin
                  state <= START;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            // Re-check the line at mid start bit to reject glitches.
            START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (!rx) begin
                     state   <= DATA;
                     bit_idx <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == BIT_M1) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= rx;
                  if (bit_idx == 3'd7) state   <= STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            // Leaving at mid stop bit lets a following start edge be caught
            // with only one stop bit between frames.
            STOP: begin
               if (cnt == BIT_M1) begin
                  cnt <= '0;
                  if (rx) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state         <= WAIT_IDLE;
                     framing_error <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= WAIT_IDLE;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Good stop bit sampled this cycle: the byte in shreg is complete.
   assign push_now = (state == STOP) && (cnt == BIT_M1) && rx;
   assign pop      = byte_stream.data_out_valid && byte_stream.data_out_ready;

`ifdef UART_RX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0] mem [FIFO_DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;   // extra MSB distinguishes full from empty

   assign byte_stream.data_out       = mem[rd_ptr[AW-1:0]];
   assign byte_stream.data_out_valid = (wr_ptr != rd_ptr);
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // When full with a pop, the write slot is the head being consumed this edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_now && (!full || pop)) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
`else
   // Depth is fixed at one in this build.
   localparam int unused_fifo_depth = FIFO_DEPTH;

   logic [7:0] hold_data;
   logic       hold_valid;

   assign byte_stream.data_out       = hold_data;
   assign byte_stream.data_out_valid = hold_valid;
   assign full                       = hold_valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hold_data  <= '0;
         hold_valid <= 1'b0;
      end else if (push_now && (!full || pop)) begin
         hold_data  <= shreg;
         hold_valid <= 1'b1;
      end else if (pop) begin
         hold_valid <= 1'b0;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) overrun <= 1'b0;
      else        overrun <= push_now && full && !pop;
   end

endmodule

// File: tb/tb_uart_byte_receiver.sv
module tb_uart_byte_receiver;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic uart_receive = 1'b1;
   logic framing_error, overrun, busy;

   int checks = 0;
   int errors = 0;

   logic [7:0] log_mem [0:255];
   int rx_n = 0;
   int fe_n = 0;
   int ov_n = 0;

   uart_byte_receiver_if byte_if ();

   uart_byte_receiver #(.CLOCK_FREQUENCY(100), .BAUD_RATE(10), .FIFO_DEPTH(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .uart_receive (uart_receive),
      .byte_stream  (byte_if.master),
      .framing_error(framing_error),
      .overrun      (overrun),
      .busy         (busy)
   );

   always #5 clock = ~clock;

   // Mid-cycle monitor: a valid&&ready seen here completes at the next rising edge.
   always @(negedge clock) begin
      if (byte_if.data_out_valid && byte_if.data_out_ready) begin
         log_mem[rx_n[7:0]] = byte_if.data_out;
         rx_n++;
      end
      if (framing_error) fe_n++;
      if (overrun) ov_n++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int low_hold);
      uart_receive = 1'b0;
      tick(10);
      for (int i = 0; i < 8; i++) begin
         uart_receive = b[i];
         tick(10);
      end
      uart_receive = stop_bit;
      tick(10);
      if (low_hold > 0) begin
         uart_receive = 1'b0;
         tick(low_hold);
      end
      uart_receive = 1'b1;
      tick(10);
   endtask

   task automatic test_reset;
      byte_if.data_out_ready = 1'b1;
      tick(3);
      checks++; if (byte_if.data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", byte_if.data_out); end
      checks++; if (byte_if.data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", byte_if.data_out_valid); end
      checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", framing_error); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b expected 0", overrun); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b1;
      tick(5);
   endtask

   task automatic test_single;
      int b0, f0, o0;
      b0 = rx_n; f0 = fe_n; o0 = ov_n;
      byte_if.data_out_ready = 1'b1;
      fork
         send_frame(8'h41, 1'b1, 0);
         begin
            repeat (97) @(posedge clock);
            @(negedge clock);
            checks++; if (byte_if.data_out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: valid %b expected 0", byte_if.data_out_valid); end
            @(negedge clock);
            checks++; if (byte_if.data_out_valid !== 1'b1) begin errors++; $display("FAIL latency_valid: valid %b expected 1", byte_if.data_out_valid); end
            checks++; if (byte_if.data_out !== 8'h41) begin errors++; $display("FAIL latency_data: got %h expected 41", byte_if.data_out); end
         end
      join
      tick(5);
      checks++; if (rx_n - b0 != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", rx_n - b0); end
      checks++; if (log_mem[b0[7:0]] !== 8'h41) begin errors++; $display("FAIL single_byte: got %h expected 41", log_mem[b0[7:0]]); end
      checks++; if (fe_n - f0 != 0 || ov_n - o0 != 0) begin errors++; $display("FAIL single_err: fe %0d ov %0d expected 0 0", fe_n - f0, ov_n - o0); end
   endtask

   task automatic test_stream;
      logic [7:0] exp_b [26];
      int b0, f0, o0;
      for (int i = 0; i < 9; i++) exp_b[i] = 8'h41 + 8'(i);
      exp_b[9] = 8'h40; exp_b[10] = 8'h41; exp_b[11] = 8'h42; exp_b[12] = 8'h43; exp_b[13] = 8'h2E;
      for (int i = 0; i < 11; i++) exp_b[14 + i] = 8'h41 + 8'(i);
      exp_b[25] = 8'h00;
      b0 = rx_n; f0 = fe_n; o0 = ov_n;
      byte_if.data_out_ready = 1'b1;
      for (int i = 0; i < 26; i++) send_frame(exp_b[i], 1'b1, 0);
      tick(5);
      checks++; if (rx_n - b0 != 26) begin errors++; $display("FAIL stream_count: got %0d expected 26", rx_n - b0); end
      for (int i = 0; i < 26; i++) begin
         checks++;
         if (log_mem[8'(b0 + i)] !== exp_b[i]) begin errors++; $display("FAIL stream_byte%0d: got %h expected %h", i, log_mem[8'(b0 + i)], exp_b[i]); end
      end
      checks++; if (fe_n - f0 != 0 || ov_n - o0 != 0) begin errors++; $display("FAIL stream_err: fe %0d ov %0d expected 0 0", fe_n - f0, ov_n - o0); end
   endtask

   task automatic test_glitch;
      int b0, f0;
      b0 = rx_n; f0 = fe_n;
      uart_receive = 1'b0;
      tick(3);
      uart_receive = 1'b1;
      tick(2);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
      tick(30);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b expected 0", busy); end
      checks++; if (rx_n - b0 != 0 || byte_if.data_out_valid !== 1'b0) begin errors++; $display("FAIL glitch_nobyte: count %0d valid %b expected 0 0", rx_n - b0, byte_if.data_out_valid); end
      checks++; if (fe_n - f0 != 0) begin errors++; $display("FAIL glitch_fe: got %0d expected 0", fe_n - f0); end
   endtask

   task automatic test_framing;
      int b0, f0, o0;
      b0 = rx_n; f0 = fe_n; o0 = ov_n;
      byte_if.data_out_ready = 1'b1;
      send_frame(8'h55, 1'b0, 20);
      tick(10);
      send_frame(8'h42, 1'b1, 0);
      tick(5);
      checks++; if (fe_n - f0 != 1) begin errors++; $display("FAIL framing_pulses: got %0d expected 1", fe_n - f0); end
      checks++; if (rx_n - b0 != 1) begin errors++; $display("FAIL framing_count: got %0d expected 1", rx_n - b0); end
      checks++; if (log_mem[b0[7:0]] !== 8'h42) begin errors++; $display("FAIL framing_next: got %h expected 42", log_mem[b0[7:0]]); end
      checks++; if (ov_n - o0 != 0) begin errors++; $display("FAIL framing_ov: got %0d expected 0", ov_n - o0); end
   endtask

   task automatic test_overrun;
      int b0, o0;
      b0 = rx_n; o0 = ov_n;
      byte_if.data_out_ready = 1'b0;
      send_frame(8'h41, 1'b1, 0);
      send_frame(8'h42, 1'b1, 0);
      send_frame(8'h43, 1'b1, 0);
      tick(5);
      checks++; if (byte_if.data_out_valid !== 1'b1 || byte_if.data_out !== 8'h41) begin errors++; $display("FAIL overrun_head: valid %b data %h expected 1 41", byte_if.data_out_valid, byte_if.data_out); end
      checks++; if (rx_n - b0 != 0) begin errors++; $display("FAIL overrun_nohs: got %0d expected 0", rx_n - b0); end
`ifdef UART_RX_FIFO_EN
      checks++; if (ov_n - o0 != 0) begin errors++; $display("FAIL overrun_pulses: got %0d expected 0", ov_n - o0); end
      byte_if.data_out_ready = 1'b1;
      tick(10);
      checks++; if (rx_n - b0 != 3) begin errors++; $display("FAIL overrun_drain_count: got %0d expected 3", rx_n - b0); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (log_mem[8'(b0 + i)] !== 8'h41 + 8'(i)) begin errors++; $display("FAIL overrun_drain%0d: got %h expected %h", i, log_mem[8'(b0 + i)], 8'h41 + 8'(i)); end
      end
      b0 = rx_n; o0 = ov_n;
      byte_if.data_out_ready = 1'b0;
      for (int i = 0; i < 17; i++) send_frame(8'h60 + 8'(i), 1'b1, 0);
      tick(5);
      checks++; if (ov_n - o0 != 1) begin errors++; $display("FAIL fifo_full_ov: got %0d expected 1", ov_n - o0); end
      byte_if.data_out_ready = 1'b1;
      tick(25);
      checks++; if (rx_n - b0 != 16) begin errors++; $display("FAIL fifo_full_count: got %0d expected 16", rx_n - b0); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (log_mem[8'(b0 + i)] !== 8'h60 + 8'(i)) begin errors++; $display("FAIL fifo_full_byte%0d: got %h expected %h", i, log_mem[8'(b0 + i)], 8'h60 + 8'(i)); end
      end
`else
      checks++; if (ov_n - o0 != 2) begin errors++; $display("FAIL overrun_pulses: got %0d expected 2", ov_n - o0); end
      byte_if.data_out_ready = 1'b1;
      tick(10);
      checks++; if (rx_n - b0 != 1) begin errors++; $display("FAIL overrun_drain_count: got %0d expected 1", rx_n - b0); end
      checks++; if (log_mem[b0[7:0]] !== 8'h41) begin errors++; $display("FAIL overrun_drain0: got %h expected 41", log_mem[b0[7:0]]); end
      checks++; if (byte_if.data_out_valid !== 1'b0) begin errors++; $display("FAIL overrun_empty: got %b expected 0", byte_if.data_out_valid); end
`endif
   endtask

   task automatic test_reset_mid;
      int b0;
      byte_if.data_out_ready = 1'b0;
      send_frame(8'h11, 1'b1, 0);
      tick(3);
      checks++; if (byte_if.data_out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", byte_if.data_out_valid); end
      uart_receive = 1'b0;
      tick(25);
      reset = 1'b0;
      byte_if.data_out_ready = 1'b1;
      tick(3);
      checks++; if (byte_if.data_out_valid !== 1'b0 || byte_if.data_out !== 8'h00) begin errors++; $display("FAIL rstmid_out: valid %b data %h expected 0 00", byte_if.data_out_valid, byte_if.data_out); end
      checks++; if (busy !== 1'b0 || framing_error !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL rstmid_flags: busy %b fe %b ov %b expected 0 0 0", busy, framing_error, overrun); end
      b0 = rx_n;
      reset = 1'b1;
      tick(120);
      checks++; if (rx_n - b0 != 0 || byte_if.data_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_low_nobyte: count %0d valid %b expected 0 0", rx_n - b0, byte_if.data_out_valid); end
      uart_receive = 1'b1;
      tick(20);
      send_frame(8'h4B, 1'b1, 0);
      tick(5);
      checks++; if (rx_n - b0 != 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", rx_n - b0); end
      checks++; if (log_mem[b0[7:0]] !== 8'h4B) begin errors++; $display("FAIL rstmid_byte: got %h expected 4b", log_mem[b0[7:0]]); end
   endtask

   initial begin
      byte_if.data_out_ready = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_glitch();
      test_framing();
      test_overrun();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
